logic_result_stage: RTL and testbench

- Pipeline stage directly downstream of the combinational logic function unit (AND/OR/XOR/NAND/NOR, 3-bit op index).
- Registers the unit's result with destination tag and op index, derives N/Z flags, and rejects op indices 3'b101..3'b111, which the logic unit does not define.
- Presents the beat to writeback through a valid/ready handshake with a 2-entry skid buffer.
- Owns the architectural N/Z flag register updated by flag-setting logic ops.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/skid_buffer.sv | 70 +++++++
 rtl/logic_result_stage.sv | 79 +++++++
 tb/tb_logic_result_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the logic function unit and its result stage.
package cpu_pkg;
  localparam logic [2:0] LOGIC_AND  = 3'b000;
  localparam logic [2:0] LOGIC_OR   = 3'b001;
  localparam logic [2:0] LOGIC_XOR  = 3'b010;
  localparam logic [2:0] LOGIC_NAND = 3'b011;
  localparam logic [2:0] LOGIC_NOR  = 3'b100;
  localparam logic [2:0] LOGIC_MAX  = 3'b100;

  localparam int LOGIC_W = 32;
  localparam int RD_W    = 4;

  typedef struct packed {
    logic [LOGIC_W-1:0] result;
    logic [RD_W-1:0]    rd;
    logic               we;
    logic               err;
    logic               n;
    logic               z;
    logic               setflags;
  } logic_beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one
// beat so the upstream ready can be a pure register.
module skid_buffer
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  skid_state_t  r_state, w_next;
  logic [W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic         r_ready;
  logic         w_accept, w_handoff;

  assign w_accept  = i_valid & r_ready;
  assign w_handoff = (r_state != EMPTY) & i_ready;

  always_comb begin
    w_next     = r_state;
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    case (r_state)
      EMPTY: if (w_accept) begin
        w_next     = ONE;
        w_main_nxt = i_data;
      end
      ONE: begin
        if (w_accept && w_handoff) begin
          w_main_nxt = i_data;
        end else if (w_accept) begin
          w_next     = FULL;
          w_skid_nxt = i_data;
        end else if (w_handoff) begin
          w_next = EMPTY;
        end
      end
      FULL: if (w_handoff) begin
        w_next     = ONE;
        w_main_nxt = r_skid;
      end
      default: w_next = EMPTY;
    endcase
  end

  // Ready is computed from the next state so it never depends on i_ready this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_ready <= (w_next != FULL);
    end
  end

  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_main;
  assign o_ready = r_ready;
endmodule

// File: rtl/logic_result_stage.sv
// Result stage after the logic unit: forms the beat (flags, illegal-op check),
// buffers it toward writeback and owns the architectural N/Z flags.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_logicidx,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_we,
  output logic             out_err,
  output logic             out_n,
  output logic             out_z,
  output logic             flag_n,
  output logic             flag_z
);
  import cpu_pkg::*;

  localparam int PL_W = $bits(logic_beat_t);

  logic_beat_t     w_in_beat, w_out_beat;
  logic [PL_W-1:0] w_out_pl;
  logic            w_err;
  logic            r_flag_n, r_flag_z;

  assign w_err = (in_logicidx > LOGIC_MAX);

  // Illegal ops still flow as a zero result so writeback can raise the fault.
  always_comb begin
    w_in_beat.result   = w_err ? '0 : in_result;
    w_in_beat.rd       = in_rd;
    w_in_beat.we       = ~w_err;
    w_in_beat.err      = w_err;
    w_in_beat.n        = ~w_err & in_result[WIDTH-1];
    w_in_beat.z        = w_err | (in_result == '0);
    w_in_beat.setflags = in_setflags;
  end

  skid_buffer #(.W(PL_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_beat),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_pl)
  );

  assign w_out_beat = logic_beat_t'(w_out_pl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (out_valid && out_ready && w_out_beat.setflags && !w_out_beat.err) begin
      r_flag_n <= w_out_beat.n;
      r_flag_z <= w_out_beat.z;
    end
  end

  assign out_result = w_out_beat.result;
  assign out_rd     = w_out_beat.rd;
  assign out_we     = w_out_beat.we;
  assign out_err    = w_out_beat.err;
  assign out_n      = w_out_beat.n;
  assign out_z      = w_out_beat.z;
  assign flag_n     = r_flag_n;
  assign flag_z     = r_flag_z;
endmodule

// File: tb/tb_logic_result_stage.sv
// Directed bench for logic_result_stage with an in-order scoreboard of expected beats.
module tb_logic_result_stage;
  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        we, err, n, z, sf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_result = '0;
  logic [2:0]  in_logicidx = '0;
  logic [3:0]  in_rd = '0;
  logic        in_setflags = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we, out_err, out_n, out_z, flag_n, flag_z;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  int   pop_cyc[$];
  logic exp_fn = 1'b0, exp_fz = 1'b0;

  logic_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_logicidx(in_logicidx), .in_rd(in_rd),
    .in_setflags(in_setflags), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_err(out_err),
    .out_n(out_n), .out_z(out_z), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [2:0] idx,
                              input logic [3:0] rd, input logic sf);
    exp_t e;
    e.err    = (idx >= 3'd5);
    e.we     = !e.err;
    e.result = e.err ? 32'h0 : r;
    e.rd     = rd;
    e.n      = e.err ? 1'b0 : r[31];
    e.z      = e.err ? 1'b1 : (r == 32'h0);
    e.sf     = sf;
    return e;
  endfunction

  // Each handoff is judged at mid-cycle, ahead of the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL mon_unexpected observed beat %h expected none", out_result);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        pop_cyc.push_back(cyc);
        chk("mon_result", out_result, e.result);
        chk("mon_rd", {28'h0, out_rd}, {28'h0, e.rd});
        chk("mon_we", {31'h0, out_we}, {31'h0, e.we});
        chk("mon_err", {31'h0, out_err}, {31'h0, e.err});
        chk("mon_n", {31'h0, out_n}, {31'h0, e.n});
        chk("mon_z", {31'h0, out_z}, {31'h0, e.z});
        if (e.sf && !e.err) begin
          exp_fn = e.n;
          exp_fz = e.z;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] r, input logic [2:0] idx,
                      input logic [3:0] rd, input logic sf);
    int n = 0;
    in_valid = 1'b1; in_result = r; in_logicidx = idx; in_rd = rd; in_setflags = sf;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk("accept_timeout", n, (n < 50) ? n : 49);
    if (in_ready) q.push_back(mk(r, idx, rd, sf));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_fn"}, {31'h0, flag_n}, {31'h0, exp_fn});
    chk({tag, "_fz"}, {31'h0, flag_z}, {31'h0, exp_fz});
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk_flags("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", {31'h0, in_ready}, 32'h1);

    // single beat, one-cycle latency, flags after handoff
    out_ready = 1'b1;
    send(32'h8000_0000, 3'b000, 4'd3, 1'b1);
    chk("lat_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    chk("single_fn", {31'h0, flag_n}, 32'h1);
    chk("single_fz", {31'h0, flag_z}, 32'h0);

    // backpressure fills the skid, then drains in order
    out_ready = 1'b0;
    send(32'h1, 3'b001, 4'd1, 1'b0);
    send(32'h2, 3'b010, 4'd2, 1'b0);
    chk("bp_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_hold0", out_result, 32'h1);
    @(posedge clk); #1;
    chk("bp_hold1", out_result, 32'h1);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_a", out_result, 32'h1);
    @(negedge clk);
    chk("bp_b", out_result, 32'h2);
    chk("bp_b_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    chk("bp_ready_back", {31'h0, in_ready}, 32'h1);
    chk("bp_empty", {31'h0, out_valid}, 32'h0);
    chk_flags("bp");

    // illegal op index
    send(32'hFFFF_FFFF, 3'b110, 4'd5, 1'b1);
    chk("ill_err", {31'h0, out_err}, 32'h1);
    chk("ill_we", {31'h0, out_we}, 32'h0);
    chk("ill_result", out_result, 32'h0);
    chk("ill_z", {31'h0, out_z}, 32'h1);
    @(posedge clk); #1;
    chk("ill_fn", {31'h0, flag_n}, 32'h1);
    chk("ill_fz", {31'h0, flag_z}, 32'h0);

    // streaming 8 beats back to back
    for (int i = 0; i < 8; i++) send(i, 3'(i % 5), 4'(i), 1'b1);
    drain();
    chk("stream_pops", pop_cyc.size(), 12);
    if (pop_cyc.size() >= 8)
      chk("stream_back2back", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-8], 7);
    chk_flags("stream");

    // setflags = 0 leaves flags alone even for a zero result
    send(32'h0, 3'b001, 4'd2, 1'b0);
    chk("nosf_z", {31'h0, out_z}, 32'h1);
    @(posedge clk); #1;
    chk("nosf_fz", {31'h0, flag_z}, 32'h0);
    chk_flags("nosf");

    // reset while FULL
    send(32'h8000_0001, 3'b011, 4'd7, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_fn", {31'h0, flag_n}, 32'h1);
    out_ready = 1'b0;
    send(32'h10, 3'b000, 4'd1, 1'b1);
    send(32'h20, 3'b000, 4'd2, 1'b1);
    chk("pre_rst_full", {31'h0, in_ready}, 32'h0);
    rst_n = 1'b0;
    q.delete();
    exp_fn = 1'b0; exp_fz = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_fn", {31'h0, flag_n}, 32'h0);
    chk("mid_rst_fz", {31'h0, flag_z}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0, 3'b100, 4'd9, 1'b1);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
    drain();
    chk_flags("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
